cp0_exc: RTL
============

CP0_EXC -- requirements
Module: cp0_exc

Interface
REQ-001 The block SHALL have parameter PRID, default 32'h4C5A_4D4A, the value read back from register 15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port A1, input, 5, the mfc0 read register number.
REQ-005 The block SHALL have port A2, input, 5, the mtc0 write register number.
REQ-006 The block SHALL have port DIn, input, 32, the mtc0 write data.
REQ-007 The block SHALL have port WE, input, 1, the mtc0 write enable.
REQ-008 The block SHALL have port PC, input, 32, the address of the instruction in the exception-sampling stage.
REQ-009 The block SHALL have port BD, input, 1, set when that instruction sits in a branch delay slot.
REQ-010 The block SHALL have port ExcCode, input, 5, the synchronous exception code; 0 means none.
REQ-011 The block SHALL have port HWInt, input, 6, hardware interrupt lines; bit 0 is timer 0 IRQ, bit 1 is timer 1 IRQ, bit 2 is the external device.
REQ-012 The block SHALL have port EXLClr, input, 1, asserted by eret.
REQ-013 The block SHALL have port Req, output, 1, the exception/interrupt request to the pipeline (flush and redirect to 0x00004180).
REQ-014 The block SHALL have port EPCOut, output, 32, the current EPC for eret.
REQ-015 The block SHALL have port DOut, output, 32, the mfc0 read data.

Function
REQ-016 Registers SHALL be implemented as follows: SR (12) with IM[15:10], EXL[1], IE[0], other bits 0; Cause (13) with BD[31], IP[15:10], ExcCode[6:2], other bits 0; EPC (14) as a full 32-bit register; PRId (15) as the read-only constant PRID.
REQ-017 Cause.IP SHALL register HWInt every cycle, so IP lags HWInt by exactly one cycle.
REQ-018 IntReq SHALL be combinational: |(IP & IM) & IE & !EXL.
REQ-019 ExcReq SHALL be combinational: (ExcCode != 0) & !EXL.
REQ-020 Req SHALL equal IntReq | ExcReq.
REQ-021 When Req=1, at the next clock edge the block SHALL set EXL<=1 and BD<=BD input.
REQ-022 When Req=1, at the next clock edge the block SHALL set Cause.ExcCode to 0 if IntReq, else to the ExcCode input; an interrupt takes priority over a simultaneous exception.
REQ-023 When Req=1, at the next clock edge the block SHALL set EPC to BD ? {PC[31:2],2'b00}-4 : {PC[31:2],2'b00}.
REQ-024 mtc0 SHALL write SR (IM, EXL and IE fields only) and EPC when WE=1; writes to Cause, PRId and undefined numbers SHALL be ignored.
REQ-025 Priority in one cycle SHALL be Req entry > EXLClr > mtc0 write; a WE targeting SR or EPC in a Req cycle SHALL be dropped.
REQ-026 EXLClr=1 without Req SHALL clear EXL at the next edge.
REQ-027 DOut SHALL be a combinational read by A1; unimplemented numbers SHALL read 0.
REQ-028 Read-after-write in the same cycle SHALL return the old value, with no internal bypass.
REQ-029 While EXL=1, Req SHALL stay 0 regardless of IP, IM, IE or ExcCode (no nesting).
REQ-030 EPCOut SHALL always equal the EPC register.

Reset
REQ-031 When reset=1 at a clock edge, the block SHALL clear SR, Cause and EPC to 0, overriding Req, EXLClr and WE.
REQ-032 After reset, Req SHALL be 0 and EPCOut SHALL be 0.
REQ-033 Reset asserted mid-handler (EXL=1) SHALL clear EXL; no pending request SHALL survive reset.

Configuration
REQ-034 Macro CP0_BADVADDR_EN defined SHALL add register 8 (BadVAddr, read-only), plus input BadAddr[31:0], loaded when Req=1 and ExcCode is 4 or 5 and not IntReq, and cleared by reset.
REQ-035 Without CP0_BADVADDR_EN, register 8 SHALL read 0 and port BadAddr SHALL not exist.

Structure
REQ-036 Package cp0_pkg SHALL hold the register numbers (8, 12, 13, 14, 15), the ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), the handler address 0x00004180, and the SR/Cause field bit positions.
REQ-037 The block SHALL have no sub-module; it is a single flat register file plus request logic.

Verification
REQ-038 The bench SHALL cover: SR=0x0000_0401 written, then HWInt=6'b000001 -> IP[10] set one cycle later, Req=1, next edge Cause.ExcCode=0 and EXL=1.
REQ-039 The bench SHALL cover: ExcCode=12, PC=0x0000_3008, BD=1 -> EPC=0x0000_3004, Cause=0x8000_0030.
REQ-040 The bench SHALL cover: EXL=1, HWInt=all ones, IM and IE set -> Req stays 0; then EXLClr pulse -> Req=1 the following cycle.
REQ-041 The bench SHALL cover: WE=1, A2=14, DIn=0x1234 in the same cycle as Req -> EPC takes the PC value, not 0x1234.
REQ-042 The bench SHALL cover: ExcCode=10 and IntReq together -> ExcCode field=0 and EPC=PC.
REQ-043 The bench SHALL cover: reset asserted while EXL=1 and Req=1 -> all registers 0 next cycle, Req=0, A1=15 reads PRID.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, handler vector and field positions.
package cp0_pkg;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  localparam int SR_IM_HI    = 15;
  localparam int SR_IM_LO    = 10;
  localparam int SR_EXL      = 1;
  localparam int SR_IE       = 0;
  localparam int CAUSE_BD    = 31;
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_EC_HI = 6;
  localparam int CAUSE_EC_LO = 2;

  // A delay-slot fault restarts at the branch, one word before the slot.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    logic [31:0] aligned;
    aligned = {pc[31:2], 2'b00};
    return bd ? aligned - 32'd4 : aligned;
  endfunction
endpackage

// File: rtl/cp0_exc.sv
// CP0 register file (SR/Cause/EPC/PRId) with interrupt/exception request logic.
// Optional BadVAddr register (8) and BadAddr input when CP0_BADVADDR_EN is defined.
module cp0_exc
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h4C5A_4D4A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] BadAddr,
`endif
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;
`ifdef CP0_BADVADDR_EN
  logic [31:0] r_badvaddr;
`endif

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_unused;

  assign w_int_req = (|(r_ip & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (ExcCode != EXC_INT) & ~r_exl;
  assign w_req     = w_int_req | w_exc_req;

  assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exc_code, 2'b00};
  assign w_unused = ^{DIn[31:16], DIn[9:2], PC[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
`ifdef CP0_BADVADDR_EN
      r_badvaddr <= '0;
`endif
    end else begin
      r_ip <= HWInt;
      if (w_req) begin
        // Entry owns SR/EPC this cycle; any concurrent mtc0 is dropped.
        r_exl      <= 1'b1;
        r_bd       <= BD;
        r_exc_code <= w_int_req ? EXC_INT : ExcCode;
        r_epc      <= epc_of(PC, BD);
`ifdef CP0_BADVADDR_EN
        if (!w_int_req && (ExcCode == EXC_ADEL || ExcCode == EXC_ADES))
          r_badvaddr <= BadAddr;
`endif
      end else begin
        if (WE && A2 == REG_SR) begin
          r_im <= DIn[SR_IM_HI:SR_IM_LO];
          r_ie <= DIn[SR_IE];
        end
        if (EXLClr)
          r_exl <= 1'b0;
        else if (WE && A2 == REG_SR)
          r_exl <= DIn[SR_EXL];
        if (WE && A2 == REG_EPC)
          r_epc <= DIn;
      end
    end
  end

  always_comb begin
    DOut = '0;
    case (A1)
      REG_SR:       DOut = w_sr;
      REG_CAUSE:    DOut = w_cause;
      REG_EPC:      DOut = r_epc;
      REG_PRID:     DOut = PRID;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: DOut = r_badvaddr;
`endif
      default:      DOut = '0;
    endcase
  end

  assign Req    = w_req;
  assign EPCOut = r_epc;

endmodule
